// File: rtl/lw_sw_multicycle_ctrl.sv
// Multicycle control FSM for the load/store datapath.
// Sequences fetch, decode, address add, memory access and write-back over
// several clocks, waits on mem_ack with a timeout, and counts retired LW/SW.
// Datapath strobes are decoded combinationally from the current state
// (plus mem_ack for the fetch strobes); state, halted and retired are registered.
module lw_sw_multicycle_ctrl #(
    parameter logic [5:0] OP_LW   = 6'h23,
    parameter logic [5:0] OP_SW   = 6'h2B,
    parameter int         CNT_W   = 16,
    parameter int         TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [5:0]       opcode,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_src,
    output logic             pc_we,
    output logic             ir_we,
    output logic             reg_we,
    output logic             illegal,
    output logic             halted,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    // Wide enough to hold TIMEOUT-1; the transition to HALT happens on the
    // un-acked cycle that would take the count to TIMEOUT.
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        MEMADR = 3'd2,
        MEMRD  = 3'd3,
        MEMWB  = 3'd4,
        MEMWR  = 3'd5,
        HALT   = 3'd6
    } state_t;

    state_t            state_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              is_lw_reg;
    logic              halted_reg;
    logic [CNT_W-1:0]  retired_reg;

    logic              opcode_ok;
    logic              wait_expired;

    assign opcode_ok    = (opcode == OP_LW) || (opcode == OP_SW);
    // Only meaningful while a request is outstanding and not acknowledged.
    assign wait_expired = (wait_cnt_reg == WAIT_LAST);

    // State sequencing, memory wait counter, fault flag and retire counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= FETCH;
            wait_cnt_reg <= '0;
            is_lw_reg    <= 1'b0;
            halted_reg   <= 1'b0;
            retired_reg  <= '0;
        end else begin
            case (state_reg)
                FETCH: begin
                    // With en low there is no request; the wait count simply holds.
                    if (en) begin
                        if (mem_ack) begin
                            state_reg    <= DECODE;
                            wait_cnt_reg <= '0;
                        end else if (wait_expired) begin
                            state_reg  <= HALT;
                            halted_reg <= 1'b1;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                        end
                    end
                end
                DECODE: begin
                    wait_cnt_reg <= '0;
                    if (opcode_ok) begin
                        is_lw_reg <= (opcode == OP_LW);
                        state_reg <= MEMADR;
                    end else begin
                        state_reg <= FETCH;
                    end
                end
                MEMADR: begin
                    // Address add cycle; the opcode latched in DECODE picks the access.
                    wait_cnt_reg <= '0;
                    state_reg    <= is_lw_reg ? MEMRD : MEMWR;
                end
                MEMRD: begin
                    if (mem_ack) begin
                        state_reg    <= MEMWB;
                        wait_cnt_reg <= '0;
                    end else if (wait_expired) begin
                        state_reg  <= HALT;
                        halted_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                    end
                end
                MEMWB: begin
                    retired_reg  <= retired_reg + CNT_W'(1);
                    wait_cnt_reg <= '0;
                    state_reg    <= FETCH;
                end
                MEMWR: begin
                    if (mem_ack) begin
                        retired_reg  <= retired_reg + CNT_W'(1);
                        wait_cnt_reg <= '0;
                        state_reg    <= FETCH;
                    end else if (wait_expired) begin
                        state_reg  <= HALT;
                        halted_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                    end
                end
                HALT: begin
                    // Only reset leaves HALT.
                    halted_reg <= 1'b1;
                end
                default: begin
                    state_reg    <= FETCH;
                    wait_cnt_reg <= '0;
                end
            endcase
        end
    end

    // Datapath strobes decoded from the current state; fetch strobes also need the ack.
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_src = 1'b0;
        pc_we    = 1'b0;
        ir_we    = 1'b0;
        reg_we   = 1'b0;
        illegal  = 1'b0;
        case (state_reg)
            FETCH: begin
                mem_req = en;
                pc_we   = en && mem_ack;
                ir_we   = en && mem_ack;
            end
            DECODE: begin
                illegal = !opcode_ok;
            end
            MEMRD: begin
                mem_req  = 1'b1;
                addr_src = 1'b1;
            end
            MEMWB: begin
                reg_we = 1'b1;
            end
            MEMWR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_src = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign halted  = halted_reg;
    assign retired = retired_reg;
    assign state   = state_reg;

endmodule

// File: tb/tb_lw_sw_multicycle_ctrl.sv
// Bench for lw_sw_multicycle_ctrl: directed scenarios with hand-computed
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the controller's instruction flow.
module tb_lw_sw_multicycle_ctrl;

    localparam int TMO = 8;
    localparam int CW  = 8;   // small counter so the wrap is reachable quickly

    // Spec-defined state numbering.
    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3,
                   S_MEMWB = 4, S_MEMWR = 5, S_HALT = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          mem_ack = 1'b0;
    logic [5:0]    opcode = 6'h00;
    logic          mem_req, mem_we, addr_src, pc_we, ir_we, reg_we, illegal, halted;
    logic [CW-1:0] retired;
    logic [2:0]    state;

    lw_sw_multicycle_ctrl #(
        .OP_LW(6'h23), .OP_SW(6'h2B), .CNT_W(CW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .opcode(opcode), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .addr_src(addr_src), .pc_we(pc_we),
        .ir_we(ir_we), .reg_we(reg_we), .illegal(illegal), .halted(halted),
        .retired(retired), .state(state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: where the instruction is, how long the current
    // request has waited, what the decoded instruction was, and the counters.
    int m_st = S_FETCH;
    int m_waited = 0;
    bit m_is_load = 1'b0;
    bit m_halt = 1'b0;
    int m_ret = 0;

    // Last sampled DUT outputs, for the directed literal checks.
    int s_state, s_req, s_we, s_as, s_pc, s_ir, s_reg, s_ill, s_halt, s_ret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare every output against the model, advance the model.
    task automatic cyc(input logic e, input logic a, input logic [5:0] op);
        bit req_x, we_x, as_x, fetch_done_x, reg_x, ill_x, legal;
        @(negedge clk);
        en = e; mem_ack = a; opcode = op;
        #1;
        legal        = (op == 6'h23) || (op == 6'h2B);
        req_x        = (m_st == S_FETCH && e) || m_st == S_MEMRD || m_st == S_MEMWR;
        we_x         = (m_st == S_MEMWR);
        as_x         = (m_st == S_MEMRD) || (m_st == S_MEMWR);
        fetch_done_x = (m_st == S_FETCH) && e && a;
        reg_x        = (m_st == S_MEMWB);
        ill_x        = (m_st == S_DECODE) && !legal;
        chk("state", 32'(state), 32'(m_st));
        chk("mem_req", 32'(mem_req), 32'(req_x));
        chk("mem_we", 32'(mem_we), 32'(we_x));
        chk("addr_src", 32'(addr_src), 32'(as_x));
        chk("pc_we", 32'(pc_we), 32'(fetch_done_x));
        chk("ir_we", 32'(ir_we), 32'(fetch_done_x));
        chk("reg_we", 32'(reg_we), 32'(reg_x));
        chk("illegal", 32'(illegal), 32'(ill_x));
        chk("halted", 32'(halted), 32'(m_halt));
        chk("retired", 32'(retired), 32'(m_ret));
        s_state = int'(state); s_req = int'(mem_req); s_we = int'(mem_we);
        s_as = int'(addr_src); s_pc = int'(pc_we); s_ir = int'(ir_we);
        s_reg = int'(reg_we); s_ill = int'(illegal); s_halt = int'(halted);
        s_ret = int'(retired);
        // Model advance for the coming rising edge.
        if (m_st == S_HALT) begin
            // stuck until reset
        end else if (req_x && !a) begin
            m_waited++;
            if (m_waited >= TMO) begin
                m_st = S_HALT;
                m_halt = 1'b1;
            end
        end else if (m_st == S_FETCH && !e) begin
            // idle, nothing outstanding
        end else begin
            m_waited = 0;
            case (m_st)
                S_FETCH:  m_st = S_DECODE;
                S_DECODE: begin
                    if (legal) begin
                        m_is_load = (op == 6'h23);
                        m_st = S_MEMADR;
                    end else begin
                        m_st = S_FETCH;
                    end
                end
                S_MEMADR: m_st = m_is_load ? S_MEMRD : S_MEMWR;
                S_MEMRD:  m_st = S_MEMWB;
                default: begin   // MEMWB, or MEMWR with ack: instruction retires
                    m_ret = (m_ret + 1) % (1 << CW);
                    m_st = S_FETCH;
                end
            endcase
        end
    endtask

    // Asynchronous reset right now; outputs must clear without waiting for a clock.
    task automatic do_reset();
        rst = 1'b0;
        en = 1'b0;
        mem_ack = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_strobes", {25'd0, mem_req, mem_we, addr_src, pc_we, ir_we, reg_we, illegal}, 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        m_st = S_FETCH; m_waited = 0; m_is_load = 1'b0; m_halt = 1'b0; m_ret = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int stall;
        logic a;
        logic [5:0] op;
        #2;
        do_reset();

        // 1: zero-wait LW -> states 0,1,2,3,4
        cyc(1, 1, 6'h23); chk("t1_c1_state", s_state, 0); chk("t1_c1_pcir", s_pc + s_ir, 2);
        cyc(1, 1, 6'h23); chk("t1_c2_state", s_state, 1);
        cyc(1, 1, 6'h23); chk("t1_c3_state", s_state, 2);
        cyc(1, 1, 6'h23); chk("t1_c4_state", s_state, 3); chk("t1_c4_regwe", s_reg, 0);
        cyc(1, 1, 6'h23); chk("t1_c5_state", s_state, 4); chk("t1_c5_regwe", s_reg, 1);
        cyc(0, 0, 6'h00); chk("t1_retired", s_ret, 1);

        // 2: zero-wait SW -> states 0,1,2,5
        cyc(1, 1, 6'h2B); cyc(1, 1, 6'h2B); cyc(1, 1, 6'h2B);
        chk("t2_c3_state", s_state, 2);
        cyc(1, 1, 6'h2B); chk("t2_c4_state", s_state, 5);
        chk("t2_c4_we_as", s_we + s_as, 2); chk("t2_c4_regwe", s_reg, 0);
        cyc(0, 0, 6'h00); chk("t2_retired", s_ret, 2);

        // 3: illegal opcode, 2 cycles, nothing retired
        cyc(1, 1, 6'h00); cyc(1, 1, 6'h00);
        chk("t3_state", s_state, 1); chk("t3_illegal", s_ill, 1);
        cyc(0, 0, 6'h00); chk("t3_back", s_state, 0); chk("t3_ill_off", s_ill, 0);
        chk("t3_retired", s_ret, 2);

        // 4a: LW with 7 wait cycles in MEMRD still completes
        cyc(1, 1, 6'h23); cyc(1, 1, 6'h23); cyc(1, 0, 6'h23);
        for (int i = 0; i < 7; i++) cyc(1, 0, 6'h23);
        chk("t4_waiting", s_state, 3);
        cyc(1, 1, 6'h23); cyc(1, 0, 6'h23); chk("t4_wb", s_reg, 1);
        cyc(0, 0, 6'h00); chk("t4_retired", s_ret, 3);
        // 4b: 8 wait cycles -> HALT, sticky
        cyc(1, 1, 6'h23); cyc(1, 1, 6'h23); cyc(1, 0, 6'h23);
        for (int i = 0; i < 8; i++) cyc(1, 0, 6'h23);
        cyc(1, 1, 6'h23); chk("t4_halt_state", s_state, 6); chk("t4_halted", s_halt, 1);
        chk("t4_halt_req", s_req, 0);
        cyc(1, 1, 6'h2B); chk("t4_halt_sticky", s_halt, 1); chk("t4_halt_pc", s_pc, 0);
        do_reset();

        // 5: reset during MEMWB, then during MEMWR
        cyc(1, 1, 6'h23); cyc(1, 1, 6'h23); cyc(1, 1, 6'h23); cyc(1, 1, 6'h23);
        cyc(1, 1, 6'h23); chk("t5_in_wb", s_state, 4);
        do_reset();
        cyc(0, 0, 6'h00); chk("t5_no_regwe", s_reg, 0);
        cyc(1, 1, 6'h2B); cyc(1, 1, 6'h2B); cyc(1, 1, 6'h2B);
        cyc(1, 0, 6'h2B); chk("t5_in_wr", s_state, 5);
        do_reset();
        cyc(0, 0, 6'h00); chk("t5_no_memwe", s_we, 0);

        // 6: retired wraps 255 -> 0
        for (int i = 0; i < 255; i++) for (int k = 0; k < 4; k++) cyc(1, 1, 6'h2B);
        cyc(0, 0, 6'h00); chk("t6_max", s_ret, 255);
        for (int k = 0; k < 4; k++) cyc(1, 1, 6'h2B);
        cyc(0, 0, 6'h00); chk("t6_wrap", s_ret, 0);

        // Randomized traffic: stalls, illegal opcodes, en toggling, resets.
        stall = 0;
        for (int n = 0; n < 6000; n++) begin
            if (stall == 0 && $urandom_range(0, 40) == 0) stall = $urandom_range(4, 10);
            if (stall > 0) begin
                a = 1'b0;
                stall--;
            end else begin
                a = ($urandom_range(0, 3) != 0);
            end
            case ($urandom_range(0, 5))
                0:       op = 6'($urandom);
                1, 2:    op = 6'h2B;
                default: op = 6'h23;
            endcase
            cyc(($urandom_range(0, 9) != 0), a, op);
            if ($urandom_range(0, 400) == 0 || (m_halt && $urandom_range(0, 15) == 0))
                do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
